// File: rtl/seq_wide_comparator_pkg.sv
// Purpose : shared types and constants for the nibble-serial wide magnitude comparator.
// Contents: FSM state encoding, one-hot {lt,eq,gt} cascade encoding, initial cascade value.
// Users   : seq_wide_comparator (top) and cmp4_cascade (compare slice).
package seq_wide_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Cascade word is {lt, eq, gt}; exactly one bit set while a compare is in flight.
  localparam logic [2:0] CASC_LT   = 3'b100;
  localparam logic [2:0] CASC_EQ   = 3'b010;
  localparam logic [2:0] CASC_GT   = 3'b001;

  // Before any nibble is seen the operands are treated as equal, so the first
  // differing nibble (walking upward) sets the answer and higher ones override it.
  localparam logic [2:0] CASC_INIT = CASC_EQ;

endpackage

// File: rtl/seq_wide_comparator_cmp4.sv
// Purpose : combinational 4-bit magnitude compare slice with {lt,eq,gt} cascade in/out.
// Latency : none (pure combinational); no flow control.
// Ports   : i_a/i_b nibbles, i_casc cascade from lower nibbles, o_casc cascade result.
module cmp4_cascade
  import seq_wide_comparator_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_casc,
  output logic [2:0] o_casc
);

  // A differing nibble decides on its own; equal nibbles defer to the lower ones.
  always_comb begin
    o_casc = i_casc;
    if (i_a > i_b) begin
      o_casc = CASC_GT;
    end else if (i_a < i_b) begin
      o_casc = CASC_LT;
    end
  end

endmodule

// File: rtl/seq_wide_comparator.sv
// Purpose : wide unsigned/two's-complement magnitude compare using one 4-bit slice over time.
// Latency : start sampled at edge k -> busy NIBBLES cycles -> done pulse in the following cycle.
// Backpressure: none; start is only accepted when busy=0 and is dropped (not queued) otherwise.
// Ports   : clk, rst_n (async, active low); start/signed_mode/A/B request; busy, done,
//           A_lt_B/A_eq_B/A_gt_B held result (all zero until the first done).
module seq_wide_comparator
  import seq_wide_comparator_pkg::*;
#(
  parameter int NIBBLES = 8,
  parameter int CNT_W   = $clog2(NIBBLES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  output logic                   busy,
  output logic                   done,
  output logic                   A_lt_B,
  output logic                   A_eq_B,
  output logic                   A_gt_B
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_signed;
  logic [CNT_W-1:0]   r_idx;
  logic [2:0]         r_casc;
  logic [2:0]         r_res;

  logic [W-1:0]       w_sign_mask;
  logic [W-1:0]       w_a_fix;
  logic [W-1:0]       w_b_fix;
  logic [IDX_W-1:0]   w_bit_idx;
  logic [3:0]         w_a_nib;
  logic [3:0]         w_b_nib;
  logic [2:0]         w_slice;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // A start in the DONE cycle chains straight into the next compare.
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

  // ---------------------------------------------------------------------------
  // Datapath: sign fix-up and nibble select
  // ---------------------------------------------------------------------------
  // Flipping the top bit maps two's-complement onto offset binary, so the
  // unsigned slice then orders signed values correctly. Only the MSB nibble sees it.
  assign w_sign_mask = {r_signed, {(W-1){1'b0}}};
  assign w_a_fix     = r_a ^ w_sign_mask;
  assign w_b_fix     = r_b ^ w_sign_mask;

  assign w_bit_idx   = {r_idx, 2'b00};
  assign w_a_nib     = w_a_fix[w_bit_idx +: 4];
  assign w_b_nib     = w_b_fix[w_bit_idx +: 4];

  cmp4_cascade u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_casc (r_casc),
    .o_casc (w_slice)
  );

  // ---------------------------------------------------------------------------
  // Operand capture, index counter, cascade and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_casc   <= '0;
      r_res    <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= A;
        r_b      <= B;
        r_signed <= signed_mode;
        r_idx    <= '0;
        r_casc   <= CASC_INIT;
      end else if (r_state == RUN) begin
        r_casc <= w_slice;
        // Index parks on the last nibble rather than wrapping.
        if (!w_last) begin
          r_idx <= r_idx + CNT_W'(1);
        end
      end

      // Result only moves on the final nibble, so it holds through later RUN phases.
      if (w_last) begin
        r_res <= w_slice;
      end
    end
  end

  assign A_lt_B = r_res[2];
  assign A_eq_B = r_res[1];
  assign A_gt_B = r_res[0];

endmodule
